// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, keeps one imem request in flight, and buffers {pc, word} pairs for decode.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_stall counters.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_valid,
    input  logic [31:0]             imem_rdata,
    input  logic                    redirect,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    inst_valid,
    output logic [31:0]             inst,
    output logic [XLEN-1:0]         inst_pc,
    input  logic                    inst_ready,
`ifdef FETCH_PERF_EN
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_stall,
`endif
    output logic [$clog2(DEPTH):0]  queue_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     word;
    } entry_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pc, req_pc;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    entry_t            mem [DEPTH];
    logic              issue, push, pop;

    // Redirect overrides every other action in its cycle.
    assign issue = (state == IDLE) && !redirect && (count < FULL);
    assign push  = (state == WAIT) && imem_valid && !redirect;
    assign pop   = inst_valid && inst_ready && !redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue) state_nxt = WAIT;
            // A redirect without the response leaves a stale word to drop.
            WAIT:    if (imem_valid) state_nxt = IDLE;
                     else if (redirect) state_nxt = DISCARD;
            DISCARD: if (imem_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req   = issue && !reset;
        inst_valid = (count != '0);
        inst       = inst_valid ? mem[rd_ptr].word : '0;
        inst_pc    = inst_valid ? mem[rd_ptr].pc   : '0;
    end

    assign imem_addr   = pc;
    assign queue_count = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else if (redirect) begin
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (issue) begin
            req_pc <= pc;
            pc     <= pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: req_pc, word: imem_rdata};
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push && perf_fetched != '1)
                perf_fetched <= perf_fetched + 32'd1;
            if (inst_ready && !inst_valid && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
